pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V core's fetch stage. It holds the fetch address and presents it to IF through a valid/ready handshake. It accepts branch/jump redirects from EX and freezes on the global `rdy` pause. Redirects that arrive during a pause are buffered, and an epoch tag is issued so IF can discard fetches from a stale path.

---
 rtl/pc_gen.sv | 88 ++++++++
 tb/tb_pc_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with valid/ready handshake, paused-redirect buffering and epoch tagging.
// Optional macro PC_ALIGN_CHECK_EN traps misaligned redirect targets instead of masking their low bits.
module pc_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INST_BYTES   = 4,
    parameter int                    EPOCH_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  pc_ready,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid,
    output logic [EPOCH_W-1:0]    epoch,
    output logic                  misalign
);
`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INST_BYTES - 1);
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pc_valid;
    logic [EPOCH_W-1:0]    r_epoch;
    logic                  r_misalign;
    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_target;
    logic                  w_take;
    logic                  w_fire;
    logic                  w_bad;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_next_pc;
    state_t                w_redir_state;
    // An incoming redirect overrides whatever was buffered during the pause.
    assign w_take   = redirect | r_pend_valid;
    assign w_target = redirect ? redirect_target : r_pend_target;
    assign w_fire   = r_pc_valid & pc_ready;
`ifdef PC_ALIGN_CHECK_EN
    assign w_bad         = |(w_target & LOW_MASK);
    assign w_next_pc     = w_target;
    assign w_redir_state = w_bad ? TRAP : RUN;
`else
    assign w_bad         = 1'b0;
    assign w_next_pc     = w_target & ~LOW_MASK;
    assign w_redir_state = RUN;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_VECTOR;
            r_pc_valid    <= 1'b0;
            r_epoch       <= '0;
            r_misalign    <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (!rdy) begin
            if (redirect) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= redirect_target;
            end
        end else begin
            r_pend_valid <= 1'b0;
            if (w_take) begin
                r_pc       <= w_next_pc;
                r_epoch    <= r_epoch + EPOCH_W'(1);
                r_misalign <= w_bad;
                r_pc_valid <= (r_state != IDLE) && !stall && !w_bad;
                r_state    <= w_redir_state;
            end else if (r_state == IDLE) begin
                r_state <= RUN;
            end else if (r_state == RUN) begin
                if (w_fire)
                    r_pc <= r_pc + ADDR_WIDTH'(INST_BYTES);
                r_pc_valid <= !stall;
            end
        end
    end
    assign pc       = r_pc;
    assign pc_valid = r_pc_valid;
    assign epoch    = r_epoch;
    assign misalign = r_misalign;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic checked against a behavioural model of pc_gen.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h100;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, stall = 1'b0, redirect = 1'b0, pc_ready = 1'b1;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc;
    logic        pc_valid, misalign;
    logic [1:0]  epoch;
    int          n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(RV), .INST_BYTES(4), .EPOCH_W(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .pc_ready(pc_ready),
        .pc(pc), .pc_valid(pc_valid), .epoch(epoch), .misalign(misalign)
    );

    // Behavioural model: "started" means the first rdy edge after reset has passed.
    logic [31:0] m_pc, m_pend_t;
    logic        m_valid, m_started, m_trap, m_mis, m_pend;
    logic [1:0]  m_epoch;

    task automatic model_reset();
        m_pc = RV; m_valid = 0; m_started = 0; m_trap = 0; m_mis = 0; m_pend = 0; m_epoch = 0; m_pend_t = 0;
    endtask

    task automatic model_edge();
        logic [31:0] t;
        logic        bad;
        if (!rdy) begin
            if (redirect) begin m_pend = 1; m_pend_t = redirect_target; end
            return;
        end
        if (redirect || m_pend) begin
            t = redirect ? redirect_target : m_pend_t;
`ifdef PC_ALIGN_CHECK_EN
            bad = (t % 4) != 0;
`else
            bad = 0;
            t = t - (t % 4);
`endif
            m_valid = m_started && !stall && !bad;
            m_pc = t; m_epoch = m_epoch + 2'd1; m_mis = bad; m_trap = bad; m_started = 1;
        end else if (!m_started) begin
            m_started = 1;
        end else if (!m_trap) begin
            if (m_valid && pc_ready) m_pc = m_pc + 32'd4;
            m_valid = !stall;
        end
        m_pend = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_total++;
        if (pc !== RV || pc_valid !== 1'b0 || epoch !== 2'd0 || misalign !== 1'b0)
            $display("FAIL reset_values: pc=%h valid=%b epoch=%0d mis=%b, want pc=%h valid=0 epoch=0 mis=0", pc, pc_valid, epoch, misalign, RV);
        else n_pass++;
        rst = 0; model_reset();
        step();
        n_total++;
        if (pc_valid !== 1'b0) $display("FAIL first_edge_valid: valid=%b want 0", pc_valid); else n_pass++;
        step();
        n_total++;
        if (pc_valid !== 1'b1 || pc !== 32'h100) $display("FAIL second_edge: pc=%h valid=%b want pc=100 valid=1", pc, pc_valid); else n_pass++;
    endtask

    task automatic test_sequential();
        step();
        n_total++;
        if (pc !== 32'h104 || epoch !== 2'd0) $display("FAIL seq_104: pc=%h epoch=%0d want 104/0", pc, epoch); else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h108 || epoch !== 2'd0) $display("FAIL seq_108: pc=%h epoch=%0d want 108/0", pc, epoch); else n_pass++;
    endtask

    task automatic test_backpressure_redirect();
        pc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (pc !== 32'h108 || pc_valid !== 1'b1) $display("FAIL hold_%0d: pc=%h valid=%b want 108/1", i, pc, pc_valid); else n_pass++;
        end
        pc_ready = 1; redirect = 1; redirect_target = 32'h2000;
        step();
        redirect = 0;
        n_total++;
        if (pc !== 32'h2000 || epoch !== 2'd1) $display("FAIL redirect_on_fire: pc=%h epoch=%0d want 2000/1", pc, epoch); else n_pass++;
    endtask

    task automatic test_pause_redirect();
        rdy = 0; redirect = 1; redirect_target = 32'h300;
        step();
        redirect_target = 32'h400;
        step();
        redirect = 0;
        step();
        n_total++;
        if (pc !== 32'h2000 || epoch !== 2'd1 || pc_valid !== 1'b1) $display("FAIL pause_frozen: pc=%h epoch=%0d valid=%b want 2000/1/1", pc, epoch, pc_valid); else n_pass++;
        rdy = 1;
        step();
        n_total++;
        if (pc !== 32'h400 || epoch !== 2'd2) $display("FAIL pend_apply: pc=%h epoch=%0d want 400/2", pc, epoch); else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h404 || epoch !== 2'd2) $display("FAIL pend_cleared: pc=%h epoch=%0d want 404/2", pc, epoch); else n_pass++;
    endtask

    task automatic test_pend_vs_incoming();
        rdy = 0; redirect = 1; redirect_target = 32'h500;
        step();
        rdy = 1; redirect_target = 32'h600;
        step();
        redirect = 0;
        n_total++;
        if (pc !== 32'h600 || epoch !== 2'd3) $display("FAIL incoming_wins: pc=%h epoch=%0d want 600/3", pc, epoch); else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h604 || epoch !== 2'd3) $display("FAIL incoming_cleared: pc=%h epoch=%0d want 604/3", pc, epoch); else n_pass++;
    endtask

    task automatic test_wrap();
        redirect = 1; redirect_target = 32'hFFFF_FFFC;
        step();
        redirect = 0;
        n_total++;
        if (pc !== 32'hFFFF_FFFC || epoch !== 2'd0 || pc_valid !== 1'b1) $display("FAIL epoch_wrap: pc=%h epoch=%0d valid=%b want fffffffc/0/1", pc, epoch, pc_valid); else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h0) $display("FAIL pc_wrap: pc=%h want 0", pc); else n_pass++;
    endtask

    task automatic test_stall_redirect();
        stall = 1; redirect = 1; redirect_target = 32'h800;
        step();
        redirect = 0;
        n_total++;
        if (pc !== 32'h800 || pc_valid !== 1'b0 || epoch !== 2'd1) $display("FAIL stall_redirect: pc=%h valid=%b epoch=%0d want 800/0/1", pc, pc_valid, epoch); else n_pass++;
        step();
        n_total++;
        if (pc !== 32'h800 || pc_valid !== 1'b0) $display("FAIL stall_hold: pc=%h valid=%b want 800/0", pc, pc_valid); else n_pass++;
        stall = 0;
        step();
        n_total++;
        if (pc !== 32'h800 || pc_valid !== 1'b1) $display("FAIL stall_release: pc=%h valid=%b want 800/1", pc, pc_valid); else n_pass++;
        step();
    endtask

    task automatic test_misalign();
        redirect = 1; redirect_target = 32'h802;
        step();
        redirect = 0;
`ifdef PC_ALIGN_CHECK_EN
        n_total++;
        if (pc !== 32'h802 || misalign !== 1'b1 || pc_valid !== 1'b0) $display("FAIL trap_enter: pc=%h mis=%b valid=%b want 802/1/0", pc, misalign, pc_valid); else n_pass++;
        step(); step();
        n_total++;
        if (pc !== 32'h802 || misalign !== 1'b1 || pc_valid !== 1'b0) $display("FAIL trap_hold: pc=%h mis=%b valid=%b want 802/1/0", pc, misalign, pc_valid); else n_pass++;
        redirect = 1; redirect_target = 32'h900;
        step();
        redirect = 0;
        n_total++;
        if (pc !== 32'h900 || misalign !== 1'b0 || pc_valid !== 1'b1) $display("FAIL trap_exit: pc=%h mis=%b valid=%b want 900/0/1", pc, misalign, pc_valid); else n_pass++;
`else
        n_total++;
        if (pc !== 32'h800 || misalign !== 1'b0 || pc_valid !== 1'b1) $display("FAIL align_mask: pc=%h mis=%b valid=%b want 800/0/1", pc, misalign, pc_valid); else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        rdy = 0; redirect = 1; redirect_target = 32'hABC0;
        step();
        redirect = 0;
        #2 rst = 1;
        #1;
        n_total++;
        if (pc !== RV || pc_valid !== 1'b0 || epoch !== 2'd0 || misalign !== 1'b0)
            $display("FAIL async_reset: pc=%h valid=%b epoch=%0d mis=%b want %h/0/0/0", pc, pc_valid, epoch, misalign, RV);
        else n_pass++;
        @(posedge clk); #1;
        rst = 0; rdy = 1; model_reset();
        step();
        n_total++;
        if (pc !== RV || epoch !== 2'd0 || pc_valid !== 1'b0) $display("FAIL reset_drops_pend: pc=%h epoch=%0d valid=%b want %h/0/0", pc, epoch, pc_valid, RV); else n_pass++;
        step();
        n_total++;
        if (pc !== RV || pc_valid !== 1'b1) $display("FAIL reset_restart: pc=%h valid=%b want %h/1", pc, pc_valid, RV); else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            rdy = $urandom_range(3) != 0;
            stall = $urandom_range(3) == 0;
            pc_ready = $urandom_range(1) != 0;
            redirect = $urandom_range(6) == 0;
            redirect_target = $urandom;
            step();
            n_total++;
            if (pc !== m_pc || pc_valid !== m_valid || epoch !== m_epoch || misalign !== m_mis) begin
                if (errs < 10)
                    $display("FAIL random_%0d: pc=%h valid=%b epoch=%0d mis=%b want %h/%b/%0d/%b", i, pc, pc_valid, epoch, misalign, m_pc, m_valid, m_epoch, m_mis);
                errs++;
            end else n_pass++;
        end
        redirect = 0; stall = 0; rdy = 1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure_redirect();
        test_pause_redirect();
        test_pend_vs_incoming();
        test_wrap();
        test_stall_redirect();
        test_misalign();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
